bin2bcd_avalon: RTL and testbench
=================================

Name: bin2bcd_avalon

Overview:
- Avalon-MM slave that accepts a binary value from the Nios II and converts it to packed BCD using a sequential shift-add-3 (double-dabble) engine.
- Sits directly upstream of the per-digit 7-segment decoders.
- Each 4-bit field of oBcd drives one decoder's data input.
- Software reads back status and the BCD result through the same slave.

Parameters:
- DATA_W, 16: binary operand width, range 4..30.
- NUM_DIGITS, 5: BCD digits produced; must be ≥ ceil(DATA_W·log10 2).

Ports:
- iClk  in  1  system clock
- iReset_n  in  1  reset
- iChip_select_n  in  1  Avalon chipselect, active-low
- iWrite_n  in  1  Avalon write, active-low
- iRead_n  in  1  Avalon read, active-low
- iAddress  in  1  0 = DATA/CTRL, 1 = RESULT
- iWriteData  in  32  Avalon writedata; bits [DATA_W-1:0] used
- oReadData  out  32  Avalon readdata, read latency 1
- oBcd  out  4·NUM_DIGITS  packed BCD; digit 0 at [3:0]
- oValid  out  1  one-cycle pulse when oBcd updates
- oBusy  out  1  conversion in progress
- oBlank  out  NUM_DIGITS  leading-zero blank mask (see Optional Feature)

Behaviour:
- Reset: iReset_n is asynchronous, active-low; clock is iClk.
  - During reset: state IDLE, oBcd = 0, oValid = 0, oBusy = 0, oReadData = 0, oBlank = 0, internal shift registers = 0, done flag = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Write strobe = ~iChip_select_n & ~iWrite_n & (iAddress == 0).
  - On the write strobe at edge 0: load bin_reg <= iWriteData[DATA_W-1:0], clear bcd_work, cnt <= DATA_W, clear done flag, go to SHIFT.
  - Bits above DATA_W-1 are ignored.
- SHIFT, each edge:
  - Every 4-bit digit of bcd_work ≥ 5 gets +3.
  - Then {bcd_work, bin_reg} shifts left by 1; bin_reg MSB enters bcd_work LSB.
  - cnt decrements; when cnt reaches 1 on this edge, go to DONE.
- DONE, one cycle:
  - oBcd <= bcd_work, oValid <= 1 for exactly one cycle, done flag <= 1, return to IDLE.
- Latency: oBcd/oValid update at edge DATA_W+1 after the accepting write (edge 17 for default).
- A new write is accepted the edge after DONE.
- oBusy = (state != IDLE), registered with state.
- Write to address 0 while busy: ignored entirely, no restart. Sticky overrun bit set.
- Write to address 1: ignored.
- Reads (chipselect & read), oReadData valid the next cycle:
  - Address 0: {29'b0, overrun, done, busy}.
  - Address 1: zero-extended oBcd.
  - Reading address 0 clears overrun on that edge. A set on the same edge wins.
- Simultaneous read and write in one cycle: both serviced; read returns pre-write state.
- Operand 0: result 0; still takes the full DATA_W+1 cycles.
- Maximum operand (2^DATA_W − 1) must fit; NUM_DIGITS too small is a parameter error (elaboration-time assertion).
- Reset mid-conversion: aborts immediately. oBcd returns to 0 and no oValid pulse occurs.
- oBcd holds its last value until the next DONE, so downstream decoders see no intermediate values.

Optional Feature:
- Macro: BIN2BCD_BLANK_EN.
- Defined: oBlank[i] = 1 for every digit i > 0 above the most significant nonzero digit of oBcd.
  - Registered and updated together with oBcd.
  - Digit 0 is never blanked.
  - The top-level uses the mask to force the corresponding display off.
- Undefined: oBlank tied to all zeros; no extra logic.

Decomposition:
- Package bin2bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE}
  - address constants ADDR_DATA = 0, ADDR_RESULT = 1
  - status bit indices STAT_BUSY = 0, STAT_DONE = 1, STAT_OVR = 2
- Sub-module bcd_add3: combinational 4-bit digit correction (in ≥ 5 ? in + 3 : in), instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset, write 0 → after 17 cycles oValid pulses once; oBcd = 0x00000; status read = 0b010.
- Write 65535 → oBcd = 0x65535 at edge 17. Address-1 read returns 0x00065535.
- Write 1234, then write 9999 at cycle 5 → second write ignored; result 0x01234; status overrun = 1, cleared after that read.
- Write 0xFFFF1234 → upper bits ignored; result 0x04660.
- Assert iReset_n low at cycle 8 of a conversion of 500 → oBcd = 0, oBusy = 0, no oValid. A subsequent write of 500 → 0x00500.
- With BIN2BCD_BLANK_EN, write 7 → oBcd = 0x00007, oBlank = 5'b11110. Write 0 → oBlank = 5'b11110. Without the macro, oBlank = 0 always.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the binary-to-BCD Avalon slave.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam logic ADDR_DATA   = 1'b0;
   localparam logic ADDR_RESULT = 1'b1;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;

   // Decimal digits needed to hold 2^dataW - 1.
   function automatic int minDigits(input int dataW);
      longint unsigned v;
      int n;
      v = (64'd1 << dataW) - 64'd1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more.
// Pure combinational; one instance per BCD digit.
module bcd_add3 (
   input  logic [3:0] iDigit,
   output logic [3:0] oDigit
);

   assign oDigit = (iDigit >= 4'd5) ? iDigit + 4'd3 : iDigit;

endmodule

// File: rtl/bin2bcd_avalon.sv
// Avalon-MM slave converting a binary operand to packed BCD (shift-add-3).
// Define BIN2BCD_BLANK_EN to drive a leading-zero blank mask on oBlank.
module bin2bcd_avalon
   import bin2bcd_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int NUM_DIGITS = 5
) (
   input  logic                      iClk,
   input  logic                      iReset_n,
   input  logic                      iChip_select_n,
   input  logic                      iWrite_n,
   input  logic                      iRead_n,
   input  logic                      iAddress,
   input  logic [31:0]               iWriteData,
   output logic [31:0]               oReadData,
   output logic [4*NUM_DIGITS-1:0]   oBcd,
   output logic                      oValid,
   output logic                      oBusy,
   output logic [NUM_DIGITS-1:0]     oBlank
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   generate
      if (DATA_W < 4 || DATA_W > 30) begin : gBadWidth
         $error("bin2bcd_avalon: DATA_W out of range 4..30");
      end
      if (NUM_DIGITS < minDigits(DATA_W)) begin : gBadDigits
         $error("bin2bcd_avalon: NUM_DIGITS too small for DATA_W");
      end
   endgenerate

   state_t              state;
   state_t              stateNext;
   logic [DATA_W-1:0]   binReg;
   logic [BW-1:0]       bcdWork;
   logic [BW-1:0]       bcdAdj;
   logic [CW-1:0]       cnt;
   logic                doneFlag;
   logic                ovr;
   logic                wrStb;
   logic                rdStb;
   logic [31:0]         statusWord;
   logic [31:0]         resultWord;
   logic                unusedBits;

   assign wrStb = ~iChip_select_n & ~iWrite_n & (iAddress == ADDR_DATA);
   assign rdStb = ~iChip_select_n & ~iRead_n;
   assign unusedBits = ^{iWriteData[31:DATA_W], bcdAdj[BW-1]};

   genvar g;
   generate
      for (g = 0; g < NUM_DIGITS; g++) begin : gAdd3
         bcd_add3 uAdd3 (
            .iDigit (bcdWork[4*g +: 4]),
            .oDigit (bcdAdj[4*g +: 4])
         );
      end
   endgenerate

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state <= IDLE;
         oBusy <= 1'b0;
      end else begin
         state <= stateNext;
         oBusy <= (stateNext != IDLE);
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (wrStb) stateNext = SHIFT;
         SHIFT:   if (cnt == CNT_ONE) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         binReg   <= '0;
         bcdWork  <= '0;
         cnt      <= '0;
         doneFlag <= 1'b0;
         oBcd     <= '0;
         oValid   <= 1'b0;
      end else begin
         oValid <= 1'b0;
         case (state)
            IDLE: begin
               if (wrStb) begin
                  binReg   <= iWriteData[DATA_W-1:0];
                  bcdWork  <= '0;
                  cnt      <= CNT_INIT;
                  doneFlag <= 1'b0;
               end
            end
            SHIFT: begin
               bcdWork <= {bcdAdj[BW-2:0], binReg[DATA_W-1]};
               binReg  <= binReg << 1;
               cnt     <= cnt - CNT_ONE;
            end
            DONE: begin
               oBcd     <= bcdWork;
               oValid   <= 1'b1;
               doneFlag <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      statusWord            = '0;
      statusWord[STAT_BUSY] = oBusy;
      statusWord[STAT_DONE] = doneFlag;
      statusWord[STAT_OVR]  = ovr;
   end

   generate
      if (BW >= 32) begin : gResTrunc
         assign resultWord = oBcd[31:0];
      end else begin : gResExt
         assign resultWord = {{(32-BW){1'b0}}, oBcd};
      end
   endgenerate

   // A write rejected while busy outranks a status read clearing the flag.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         ovr       <= 1'b0;
         oReadData <= '0;
      end else begin
         if (wrStb && state != IDLE)
            ovr <= 1'b1;
         else if (rdStb && iAddress == ADDR_DATA)
            ovr <= 1'b0;
         if (rdStb)
            oReadData <= (iAddress == ADDR_DATA) ? statusWord : resultWord;
      end
   end

`ifdef BIN2BCD_BLANK_EN
   logic [NUM_DIGITS-1:0] blankNext;
   logic                  zeroAbove;

   always_comb begin
      blankNext = '0;
      zeroAbove = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zeroAbove    = zeroAbove & (bcdWork[4*i +: 4] == 4'd0);
         blankNext[i] = zeroAbove;
      end
   end

   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n)
         oBlank <= '0;
      else if (state == DONE)
         oBlank <= blankNext;
   end
`else
   assign oBlank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_avalon.sv
// Self-checking bench for bin2bcd_avalon: vector table plus corner sequences.
// Build with BIN2BCD_BLANK_EN defined to also check the blank mask.
module tb_bin2bcd_avalon;

   localparam int DW = 16;
   localparam int ND = 5;

   logic        iClk = 1'b0;
   logic        iReset_n;
   logic        iChip_select_n;
   logic        iWrite_n;
   logic        iRead_n;
   logic        iAddress;
   logic [31:0] iWriteData;
   logic [31:0] oReadData;
   logic [19:0] oBcd;
   logic        oValid;
   logic        oBusy;
   logic [4:0]  oBlank;

   bin2bcd_avalon #(.DATA_W(DW), .NUM_DIGITS(ND)) dut (
      .iClk           (iClk),
      .iReset_n       (iReset_n),
      .iChip_select_n (iChip_select_n),
      .iWrite_n       (iWrite_n),
      .iRead_n        (iRead_n),
      .iAddress       (iAddress),
      .iWriteData     (iWriteData),
      .oReadData      (oReadData),
      .oBcd           (oBcd),
      .oValid         (oValid),
      .oBusy          (oBusy),
      .oBlank         (oBlank)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [31:0] din;
      logic [19:0] exp;
   } vec_t;

   vec_t        vecs[10];
   logic [19:0] sbq[$];
   logic [19:0] lastBcd;
   int          nCmp = 0;
   int          nErr = 0;

   function automatic logic [19:0] refBcd(input logic [31:0] din);
      int unsigned v;
      logic [19:0] r;
      v = din & 32'h0000FFFF;
      r = '0;
      for (int d = 0; d < ND; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [4:0] refBlank(input logic [19:0] b);
      int top;
      logic [4:0] r;
      top = 0;
      for (int d = 1; d < ND; d++)
         if (b[4*d +: 4] != 4'd0) top = d;
      r = '0;
      for (int d = 1; d < ND; d++)
         r[d] = (d > top);
`ifdef BIN2BCD_BLANK_EN
      return r;
`else
      return 5'b0;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic busWrite(input logic a, input logic [31:0] d,
                           input bit accept);
      iChip_select_n = 1'b0;
      iWrite_n       = 1'b0;
      iAddress       = a;
      iWriteData     = d;
      if (accept) sbq.push_back(refBcd(d));
      @(posedge iClk);
      #1;
      iChip_select_n = 1'b1;
      iWrite_n       = 1'b1;
   endtask

   task automatic busRead(input logic a, output logic [31:0] d);
      iChip_select_n = 1'b0;
      iRead_n        = 1'b0;
      iAddress       = a;
      @(posedge iClk);
      #1;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
      d = oReadData;
   endtask

   task automatic busReadWrite(input logic [31:0] d,
                               output logic [31:0] rd);
      iChip_select_n = 1'b0;
      iRead_n        = 1'b0;
      iWrite_n       = 1'b0;
      iAddress       = 1'b0;
      iWriteData     = d;
      sbq.push_back(refBcd(d));
      @(posedge iClk);
      #1;
      iChip_select_n = 1'b1;
      iRead_n        = 1'b1;
      iWrite_n       = 1'b1;
      rd = oReadData;
   endtask

   task automatic waitResult(input string nm, input int expLat);
      logic [19:0] exp;
      bit got;
      got = 0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(posedge iClk);
         #1;
         if (oValid) begin
            got = 1;
            exp = (sbq.size() > 0) ? sbq.pop_front() : 20'hxxxxx;
            chk({nm, " bcd"}, 32'(oBcd), 32'(exp));
            chk({nm, " latency"}, n, expLat);
            chk({nm, " blank"}, 32'(oBlank), 32'(refBlank(exp)));
            lastBcd = exp;
            @(posedge iClk);
            #1;
            chk({nm, " valid pulse width"}, 32'(oValid), 32'd0);
         end else if (oBcd !== lastBcd) begin
            chk({nm, " bcd hold"}, 32'(oBcd), 32'(lastBcd));
         end
      end
      if (!got) begin
         nCmp++;
         nErr++;
         $display("FAIL %s: timeout got no oValid expected one", nm);
      end
   endtask

   logic [31:0] rd;
   logic [31:0] rv;
   bit          sawValid;

   initial begin
      vecs[0] = '{32'd65535,      20'h65535};
      vecs[1] = '{32'hFFFF1234,   20'h04660};
      vecs[2] = '{32'd7,          20'h00007};
      vecs[3] = '{32'd9,          20'h00009};
      vecs[4] = '{32'd10,         20'h00010};
      vecs[5] = '{32'd99,         20'h00099};
      vecs[6] = '{32'd100,        20'h00100};
      vecs[7] = '{32'd4095,       20'h04095};
      vecs[8] = '{32'd50000,      20'h50000};
      vecs[9] = '{32'd12345,      20'h12345};

      iReset_n       = 1'b0;
      iChip_select_n = 1'b1;
      iWrite_n       = 1'b1;
      iRead_n        = 1'b1;
      iAddress       = 1'b0;
      iWriteData     = '0;
      lastBcd        = '0;
      repeat (3) @(posedge iClk);
      #1;
      chk("reset bcd", 32'(oBcd), 32'd0);
      chk("reset valid", 32'(oValid), 32'd0);
      chk("reset busy", 32'(oBusy), 32'd0);
      chk("reset readdata", oReadData, 32'd0);
      chk("reset blank", 32'(oBlank), 32'd0);
      iReset_n = 1'b1;
      @(posedge iClk);
      #1;
      busRead(1'b0, rd);
      chk("status after reset", rd, 32'd0);

      busWrite(1'b0, 32'd0, 1'b1);
      waitResult("zero", 17);
      busRead(1'b0, rd);
      chk("status after zero", rd, 32'b010);

      for (int i = 0; i < 10; i++) begin
         busWrite(1'b0, vecs[i].din, 1'b1);
         chk($sformatf("vec%0d busy", i), 32'(oBusy), 32'd1);
         waitResult($sformatf("vec%0d", i), 17);
         busRead(1'b1, rd);
         chk($sformatf("vec%0d result read", i), rd, 32'(vecs[i].exp));
      end

      for (int i = 0; i < 4; i++) begin
         rv = $urandom_range(0, 65535);
         busWrite(1'b0, rv, 1'b1);
         waitResult($sformatf("rand%0d", i), 17);
      end

      busWrite(1'b0, 32'd1234, 1'b1);
      repeat (4) begin
         @(posedge iClk);
         #1;
      end
      busWrite(1'b0, 32'd9999, 1'b0);
      waitResult("overrun", 12);
      busRead(1'b0, rd);
      chk("status overrun set", rd, 32'b110);
      busRead(1'b0, rd);
      chk("status overrun cleared", rd, 32'b010);

      busWrite(1'b1, 32'd123, 1'b0);
      chk("addr1 write ignored", 32'(oBusy), 32'd0);

      busWrite(1'b0, 32'd42, 1'b1);
      busRead(1'b0, rd);
      chk("status while busy", rd, 32'b001);
      waitResult("busy read", 16);

      busReadWrite(32'd321, rd);
      chk("read with write", rd, 32'b010);
      waitResult("rw", 17);

      busWrite(1'b0, 32'd500, 1'b0);
      repeat (7) begin
         @(posedge iClk);
         #1;
      end
      iReset_n = 1'b0;
      #1;
      chk("abort bcd", 32'(oBcd), 32'd0);
      chk("abort busy", 32'(oBusy), 32'd0);
      chk("abort valid", 32'(oValid), 32'd0);
      repeat (2) @(posedge iClk);
      #1;
      iReset_n = 1'b1;
      lastBcd  = '0;
      sawValid = 0;
      repeat (25) begin
         @(posedge iClk);
         #1;
         if (oValid) sawValid = 1;
      end
      chk("no valid after abort", 32'(sawValid), 32'd0);
      busWrite(1'b0, 32'd500, 1'b1);
      waitResult("after abort", 17);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
